// File: rtl/axis_uart_rx_os.sv
// Oversampling UART receiver: majority-voted bit sampling, optional parity,
// framing/break detection, single-entry AXI-Stream master output.
module axis_uart_rx_os #(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  uart_rx_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [1:0]            m_axis_tuser_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  overrun_o
);

    localparam int unsigned DIV_RAW = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned MID     = OVERSAMPLE / 2;
    localparam bit          HAS_PAR = (PARITY != 0);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  SMP_A    = OS_W'(MID - 1);
    localparam logic [OS_W-1:0]  SMP_B    = OS_W'(MID);
    localparam logic [OS_W-1:0]  SMP_C    = OS_W'(MID + 1);
    localparam logic [OS_W-1:0]  SMP_MAX  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_rx_meta, r_rx_sync, r_rx_prev;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [OS_W-1:0]       r_smp_cnt;
    logic                  r_s0, r_s1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_par_err;

    logic w_fall, w_tick, w_decide, w_vote, w_all_zero, w_par_exp;
    logic w_start, w_cnt_clr, w_cnt_run, w_shift_en, w_par_chk, w_done;

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_tick     = (r_div_cnt == DIV_MAX);
    assign w_decide   = w_tick && (r_smp_cnt == SMP_C);
    assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
    assign w_all_zero = (r_shift == '0);
    assign w_par_exp  = (PARITY == 1) ? ~(^r_shift) : (^r_shift);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fall)   w_state_nxt = S_START;
            S_START:  if (w_decide) w_state_nxt = w_vote ? S_IDLE : S_DATA;
            S_DATA:   if (w_decide && (r_bit_cnt == BIT_LAST))
                          w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (w_decide) w_state_nxt = S_STOP;
            S_STOP:   if (w_decide) w_state_nxt = (!w_vote && w_all_zero) ? S_BREAK : S_IDLE;
            // Leave break only after a full bit time of continuous idle-high line
            S_BREAK:  if (r_rx_sync && w_tick && (r_smp_cnt == SMP_MAX)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_run  = 1'b1;
        w_shift_en = 1'b0;
        w_par_chk  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_run = 1'b0;
                w_start   = w_fall;
                w_cnt_clr = w_fall;
            end
            S_DATA:   w_shift_en = w_decide;
            S_PARITY: w_par_chk  = w_decide;
            S_STOP: begin
                w_done    = w_decide;
                w_cnt_clr = w_decide && !w_vote && w_all_zero;
            end
            S_BREAK:  w_cnt_clr = ~r_rx_sync;
            default: ;
        endcase
    end

    // Synchronizer, edge history and bit-timing counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_div_cnt <= '0;
            r_smp_cnt <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (w_cnt_clr) begin
                r_div_cnt <= '0;
                r_smp_cnt <= '0;
            end else if (w_cnt_run) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_smp_cnt <= (r_smp_cnt == SMP_MAX) ? '0 : r_smp_cnt + OS_W'(1);
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end
            if (w_tick && (r_smp_cnt == SMP_A)) r_s0 <= r_rx_sync;
            if (w_tick && (r_smp_cnt == SMP_B)) r_s1 <= r_rx_sync;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_shift_en) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            if (w_start)         r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (w_start)        r_par_err <= 1'b0;
            else if (w_par_chk) r_par_err <= (w_vote != w_par_exp);
        end
    end

    // Single-entry output; a frame completing while the word is held is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_axis_tdata_o  <= '0;
            m_axis_tuser_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (m_axis_tvalid_o && m_axis_tready_i) m_axis_tvalid_o <= 1'b0;
            if (w_done) begin
                if (!m_axis_tvalid_o || m_axis_tready_i) begin
                    m_axis_tdata_o  <= r_shift;
                    m_axis_tuser_o  <= {r_par_err, ~w_vote};
                    m_axis_tvalid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx_os.sv
// Directed bench for axis_uart_rx_os: one no-parity and one even-parity instance,
// each with its own serial line, 160 clk per bit.
module tb_axis_uart_rx_os;

    localparam int BIT_CLK   = 160;
    localparam int STOP_OFS0 = 1542;  // line start edge -> tvalid sample, 8N1
    localparam int STOP_OFS2 = 1702;  // same with a parity bit

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic line = 1'b1;
    logic sel_par = 1'b0;
    logic rdy0 = 1'b1, rdy2 = 1'b1;
    logic rx0, rx2;
    logic [7:0] tdata0, tdata2;
    logic [1:0] tuser0, tuser2;
    logic tvalid0, tvalid2, ovr0, ovr2;

    assign rx0 = sel_par ? 1'b1 : line;
    assign rx2 = sel_par ? line : 1'b1;

    axis_uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
                      .PARITY(0), .OVERSAMPLE(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx0),
        .m_axis_tdata_o(tdata0), .m_axis_tuser_o(tuser0), .m_axis_tvalid_o(tvalid0),
        .m_axis_tready_i(rdy0), .overrun_o(ovr0));

    axis_uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .DATA_WIDTH(8),
                      .PARITY(2), .OVERSAMPLE(16)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx2),
        .m_axis_tdata_o(tdata2), .m_axis_tuser_o(tuser2), .m_axis_tvalid_o(tvalid2),
        .m_axis_tready_i(rdy2), .overrun_o(ovr2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchecks = 0;
    int nerr = 0;

    logic [7:0] q0_d[$], q2_d[$];
    logic [1:0] q0_u[$], q2_u[$];
    int         q0_c[$], q2_c[$];
    int v0_hi = 0, ovr0_cnt = 0, ovr0_cyc = -1, ovr2_cnt = 0;

    // Observe transfers and pulses away from the active edge
    always @(negedge clk) begin
        if (tvalid0) v0_hi++;
        if (tvalid0 && rdy0) begin
            q0_d.push_back(tdata0); q0_u.push_back(tuser0); q0_c.push_back(cyc);
        end
        if (tvalid2 && rdy2) begin
            q2_d.push_back(tdata2); q2_u.push_back(tuser2); q2_c.push_back(cyc);
        end
        if (ovr0) begin ovr0_cnt++; ovr0_cyc = cyc; end
        if (ovr2) ovr2_cnt++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) step();
    endtask

    task automatic hold_low(input int n);
        line = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_q();
        q0_d.delete(); q0_u.delete(); q0_c.delete();
        q2_d.delete(); q2_u.delete(); q2_c.delete();
    endtask

    // par: 0 none, 1 correct even parity, 2 inverted even parity
    task automatic send_frame(input logic [7:0] d, input int par, input logic stop_b,
                              input int glitch_bit, input int rst_at, output int t0);
        logic [10:0] bits;
        int nb;
        nb = (par != 0) ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (par != 0) begin
            bits[9]  = (^d) ^ (par == 2);
            bits[10] = stop_b;
        end else begin
            bits[9] = stop_b;
        end
        t0 = cyc + 1;
        for (int idx = 0; idx < nb * BIT_CLK; idx++) begin
            int b, c;
            b = idx / BIT_CLK;
            c = idx % BIT_CLK;
            line = bits[b];
            if (b == glitch_bit && c >= 75 && c < 85) line = ~bits[b];
            if (idx == rst_at) begin
                // The transmitter is abandoned along with the receiver; line returns idle
                rst = 1'b1;
                step();
                rst = 1'b0;
                line = 1'b1;
                break;
            end
            step();
        end
        line = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; line = 1'b1; sel_par = 1'b0; rdy0 = 1'b1; rdy2 = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        @(negedge clk);
        nchecks++; if (tvalid0 !== 1'b0) begin nerr++; $display("FAIL reset_tvalid0: got %b want 0", tvalid0); end
        nchecks++; if (tdata0 !== 8'h00) begin nerr++; $display("FAIL reset_tdata0: got %h want 00", tdata0); end
        nchecks++; if (tuser0 !== 2'b00) begin nerr++; $display("FAIL reset_tuser0: got %b want 00", tuser0); end
        nchecks++; if (ovr0 !== 1'b0) begin nerr++; $display("FAIL reset_overrun0: got %b want 0", ovr0); end
        nchecks++; if (tvalid2 !== 1'b0) begin nerr++; $display("FAIL reset_tvalid2: got %b want 0", tvalid2); end
        step();
    endtask

    task automatic test_glitch();
        int t0;
        logic [7:0] gd; logic [1:0] gu; int gc;
        sel_par = 1'b0; rdy0 = 1'b1;
        idle(50);
        clear_q(); v0_hi = 0;
        send_frame(8'hA5, 0, 1'b1, 1, -1, t0);
        idle(200);
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        gu = (q0_u.size() > 0) ? q0_u[0] : 2'b11;
        gc = (q0_c.size() > 0) ? q0_c[0] : -1;
        nchecks++; if (q0_d.size() !== 1) begin nerr++; $display("FAIL glitch_count: got %0d words want 1", q0_d.size()); end
        nchecks++; if (gd !== 8'hA5) begin nerr++; $display("FAIL glitch_tdata: got %h want a5", gd); end
        nchecks++; if (gu !== 2'b00) begin nerr++; $display("FAIL glitch_tuser: got %b want 00", gu); end
        nchecks++; if (gc !== t0 + STOP_OFS0) begin nerr++; $display("FAIL glitch_latency: got cycle %0d want %0d", gc, t0 + STOP_OFS0); end
        nchecks++; if (v0_hi !== 1) begin nerr++; $display("FAIL glitch_tvalid_width: got %0d cycles want 1", v0_hi); end
    endtask

    task automatic test_parity();
        int t0, t1;
        logic [7:0] d0, d1; logic [1:0] u0, u1; int c0;
        sel_par = 1'b1; rdy2 = 1'b1;
        idle(50);
        clear_q();
        send_frame(8'h3C, 1, 1'b1, -1, -1, t0);
        idle(100);
        send_frame(8'h3C, 2, 1'b1, -1, -1, t1);
        idle(200);
        d0 = (q2_d.size() > 0) ? q2_d[0] : 8'h00;
        u0 = (q2_u.size() > 0) ? q2_u[0] : 2'b11;
        c0 = (q2_c.size() > 0) ? q2_c[0] : -1;
        d1 = (q2_d.size() > 1) ? q2_d[1] : 8'h00;
        u1 = (q2_u.size() > 1) ? q2_u[1] : 2'b11;
        nchecks++; if (q2_d.size() !== 2) begin nerr++; $display("FAIL parity_count: got %0d words want 2", q2_d.size()); end
        nchecks++; if (d0 !== 8'h3C) begin nerr++; $display("FAIL parity_ok_tdata: got %h want 3c", d0); end
        nchecks++; if (u0 !== 2'b00) begin nerr++; $display("FAIL parity_ok_tuser: got %b want 00", u0); end
        nchecks++; if (c0 !== t0 + STOP_OFS2) begin nerr++; $display("FAIL parity_latency: got cycle %0d want %0d", c0, t0 + STOP_OFS2); end
        nchecks++; if (d1 !== 8'h3C) begin nerr++; $display("FAIL parity_bad_tdata: got %h want 3c", d1); end
        nchecks++; if (u1 !== 2'b10) begin nerr++; $display("FAIL parity_bad_tuser: got %b want 10", u1); end
        sel_par = 1'b0;
        idle(20);
    endtask

    task automatic test_framing();
        int t0;
        logic [7:0] gd; logic [1:0] gu;
        sel_par = 1'b0; rdy0 = 1'b1;
        clear_q();
        send_frame(8'h81, 0, 1'b0, -1, -1, t0);
        idle(200);
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        gu = (q0_u.size() > 0) ? q0_u[0] : 2'b11;
        nchecks++; if (gd !== 8'h81) begin nerr++; $display("FAIL frame_tdata: got %h want 81", gd); end
        nchecks++; if (gu !== 2'b01) begin nerr++; $display("FAIL frame_tuser: got %b want 01", gu); end
        clear_q();
        hold_low(20 * BIT_CLK);
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'hFF;
        gu = (q0_u.size() > 0) ? q0_u[0] : 2'b11;
        nchecks++; if (q0_d.size() !== 1) begin nerr++; $display("FAIL break_count: got %0d words want 1", q0_d.size()); end
        nchecks++; if (gd !== 8'h00) begin nerr++; $display("FAIL break_tdata: got %h want 00", gd); end
        nchecks++; if (gu !== 2'b01) begin nerr++; $display("FAIL break_tuser: got %b want 01", gu); end
        // High for less than a bit time must not end the break
        idle(100);
        hold_low(400);
        idle(300);
        nchecks++; if (q0_d.size() !== 1) begin nerr++; $display("FAIL break_hold: got %0d words want 1", q0_d.size()); end
        clear_q();
        send_frame(8'h5A, 0, 1'b1, -1, -1, t0);
        idle(200);
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        gu = (q0_u.size() > 0) ? q0_u[0] : 2'b11;
        nchecks++; if (gd !== 8'h5A) begin nerr++; $display("FAIL after_break_tdata: got %h want 5a", gd); end
        nchecks++; if (gu !== 2'b00) begin nerr++; $display("FAIL after_break_tuser: got %b want 00", gu); end
    endtask

    task automatic test_false_start();
        int t0;
        logic [7:0] gd; logic [1:0] gu;
        sel_par = 1'b0; rdy0 = 1'b1;
        clear_q();
        hold_low(60);
        idle(400);
        nchecks++; if (q0_d.size() !== 0) begin nerr++; $display("FAIL false_start_words: got %0d want 0", q0_d.size()); end
        send_frame(8'h33, 0, 1'b1, -1, -1, t0);
        idle(200);
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        gu = (q0_u.size() > 0) ? q0_u[0] : 2'b11;
        nchecks++; if (q0_d.size() !== 1) begin nerr++; $display("FAIL false_start_next_count: got %0d want 1", q0_d.size()); end
        nchecks++; if (gd !== 8'h33) begin nerr++; $display("FAIL false_start_next_tdata: got %h want 33", gd); end
        nchecks++; if (gu !== 2'b00) begin nerr++; $display("FAIL false_start_next_tuser: got %b want 00", gu); end
    endtask

    task automatic test_overrun();
        int ta, tb;
        logic [7:0] gd;
        sel_par = 1'b0; rdy0 = 1'b0;
        clear_q(); ovr0_cnt = 0; ovr0_cyc = -1;
        send_frame(8'h11, 0, 1'b1, -1, -1, ta);
        idle(50);
        send_frame(8'h22, 0, 1'b1, -1, -1, tb);
        idle(200);
        @(negedge clk);
        nchecks++; if (tvalid0 !== 1'b1) begin nerr++; $display("FAIL ovr_tvalid_held: got %b want 1", tvalid0); end
        nchecks++; if (tdata0 !== 8'h11) begin nerr++; $display("FAIL ovr_tdata_held: got %h want 11", tdata0); end
        nchecks++; if (tuser0 !== 2'b00) begin nerr++; $display("FAIL ovr_tuser_held: got %b want 00", tuser0); end
        nchecks++; if (ovr0_cnt !== 1) begin nerr++; $display("FAIL ovr_pulses: got %0d want 1", ovr0_cnt); end
        nchecks++; if (ovr0_cyc !== tb + STOP_OFS0) begin nerr++; $display("FAIL ovr_timing: got cycle %0d want %0d", ovr0_cyc, tb + STOP_OFS0); end
        step();
        rdy0 = 1'b1;
        repeat (5) step();
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        nchecks++; if (q0_d.size() !== 1) begin nerr++; $display("FAIL ovr_release_count: got %0d want 1", q0_d.size()); end
        nchecks++; if (gd !== 8'h11) begin nerr++; $display("FAIL ovr_release_tdata: got %h want 11", gd); end
        idle(2000);
        nchecks++; if (q0_d.size() !== 1) begin nerr++; $display("FAIL ovr_dropped_word: got %0d words want 1", q0_d.size()); end
        nchecks++; if (tvalid0 !== 1'b0) begin nerr++; $display("FAIL ovr_tvalid_after: got %b want 0", tvalid0); end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [7:0] gd; logic [1:0] gu;
        sel_par = 1'b0; rdy0 = 1'b1;
        clear_q(); ovr0_cnt = 0;
        send_frame(8'h55, 0, 1'b1, -1, 5 * BIT_CLK + 80, t0);
        @(negedge clk);
        nchecks++; if (tvalid0 !== 1'b0) begin nerr++; $display("FAIL midrst_tvalid: got %b want 0", tvalid0); end
        nchecks++; if (tdata0 !== 8'h00) begin nerr++; $display("FAIL midrst_tdata: got %h want 00", tdata0); end
        nchecks++; if (tuser0 !== 2'b00) begin nerr++; $display("FAIL midrst_tuser: got %b want 00", tuser0); end
        nchecks++; if (ovr0 !== 1'b0) begin nerr++; $display("FAIL midrst_overrun: got %b want 0", ovr0); end
        step();
        idle(1800);
        nchecks++; if (q0_d.size() !== 0) begin nerr++; $display("FAIL midrst_words: got %0d want 0", q0_d.size()); end
        send_frame(8'h7E, 0, 1'b1, -1, -1, t0);
        idle(200);
        gd = (q0_d.size() > 0) ? q0_d[0] : 8'h00;
        gu = (q0_u.size() > 0) ? q0_u[0] : 2'b11;
        nchecks++; if (gd !== 8'h7E) begin nerr++; $display("FAIL midrst_next_tdata: got %h want 7e", gd); end
        nchecks++; if (gu !== 2'b00) begin nerr++; $display("FAIL midrst_next_tuser: got %b want 00", gu); end
        nchecks++; if (ovr2_cnt !== 0) begin nerr++; $display("FAIL parity_dut_overrun: got %0d want 0", ovr2_cnt); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_parity();
        test_framing();
        test_false_start();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/axis_uart_rx_os.md
# axis_uart_rx_os

Oversampling UART receiver with an AXI-Stream master output. It converts the asynchronous serial line into bytes for the stream fabric, and is the receive-side counterpart to the stream-to-UART transmit path. The line is sampled at OVERSAMPLE× the baud rate with majority voting. Optional parity is supported. Framing, parity and overrun conditions are reported per word or by pulse.

## Interface
- CLK_FREQ, 27_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- DATA_WIDTH, 8: data bits per frame (5–9).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- OVERSAMPLE, 16: ticks per bit; must be even and ≥ 8.

- clk_i  in  1  system clock; one clock only.
- rst_i  in  1  reset, synchronous and active-high.
- uart_rx_i  in  1  asynchronous serial input; idles high.
- m_axis_tdata_o  out  DATA_WIDTH  received word, LSB first on the line.
- m_axis_tuser_o  out  2  [0] framing error, [1] parity error.
- m_axis_tvalid_o  out  1  word valid.
- m_axis_tready_i  in  1  downstream ready.
- overrun_o  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- Input path: uart_rx_i passes through a 2-FF synchronizer. Both flops reset to 1.
- Tick prescaler: DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), an integer with rounding. Example: 27 MHz / 115200 / 16 gives 15.
- Sample counter: counts 0..OVERSAMPLE-1 ticks within each bit.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: a falling edge on the synchronized line clears the prescaler and the sample counter, then → START.
- Majority vote: each bit takes three samples at ticks OS/2-1, OS/2 and OS/2+1. The bit decision is made at tick OS/2+1.
- START: if the voted bit is 1, it is a false start → IDLE with no output. If it is 0, → DATA.
- DATA: shifts in DATA_WIDTH voted bits, LSB first. → PARITY if PARITY≠0, otherwise → STOP.
- PARITY: compares the voted bit with the computed parity (odd or even). A mismatch sets the parity error flag. → STOP.
- STOP, voted bit 1: the frame completes and the FSM → IDLE immediately at the decision tick. The next start edge may then land in the second half of the stop bit.
- STOP, voted bit 0: framing error. If all data bits and the stop bit are 0, it is a break → BREAK; otherwise → IDLE.
- BREAK: the frame is still delivered. The FSM waits until the synchronized line has been high for one full bit time, then → IDLE.
- Delivery, output free: on frame completion with tvalid low, load tdata and tuser and set tvalid.
- Delivery, output occupied: if tvalid is already high, the new frame is discarded. The held word and tuser stay unchanged, and overrun_o pulses for one cycle.
- Handshake: the word transfers when tvalid && tready. tvalid then drops in the next cycle unless a new frame completes in that same cycle. In that case the new word loads and tvalid stays high.
- tdata and tuser stay stable while tvalid=1 && tready=0.

## Timing
- Reset values: tvalid 0, tdata 0, tuser 0, overrun_o 0, FSM in IDLE, synchronizer 1, counters 0.
- A reset in the middle of a frame discards the partial frame. After reset is released, the FSM waits in IDLE for a new falling edge.
- Start detection lags the line edge by 3 clk: 2 for the synchronizer, 1 for the edge detect.
- tvalid asserts 1 clk after the stop-bit decision cycle. overrun_o asserts in that same cycle.
- Nominal frame length: (1 + DATA_WIDTH + (PARITY≠0) + 1) × OVERSAMPLE × DIV clk.
- Glitch tolerance: a low pulse shorter than OS/2 ticks is rejected as a false start. A single-tick glitch at a sampling point is outvoted.
- The prescaler wraps at DIV-1. The sample counter wraps at OVERSAMPLE-1.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, which gives DIV=10 and 160 clk per bit.

1. PARITY=0, tready=1, send 0xA5, with a 10-clk low glitch centred on data bit 0 → tdata=0xA5, tuser=0, tvalid high for exactly 1 clk, 1 clk after the stop decision.
2. PARITY=2, send 0x3C with a correct parity bit, then 0x3C with the parity bit inverted → first word tuser=2'b00, second word tuser=2'b10, tdata=0x3C both times.
3. Stop bit forced to 0 on 0x81 → tuser=2'b01, tdata=0x81. Then hold the line low for 20 bit times → exactly one word 0x00 with tuser=2'b01. No further words until the line is high for ≥160 clk. A following 0x5A is received correctly.
4. Low pulse of 60 clk on an idle line → no tvalid, FSM back in IDLE. A following 0x33 is received correctly.
5. tready=0, send 0x11 then 0x22 → tvalid held with 0x11, overrun_o pulses exactly once at the end of 0x22. Raise tready → 0x11 transfers once, and 0x22 never appears.
6. Assert rst_i for 1 clk during data bit 4 of 0x55 → all outputs 0 and no word is emitted. A subsequent 0x7E → tdata=0x7E, tuser=0.
